// File: rtl/mem_wb_pkg.sv
// Shared types and default sizing for the mem_wb arbitration slice.
package mem_wb_pkg;

    localparam int MEM_AW      = 8;
    localparam int MEM_DW      = 8;
    localparam int ARB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 upward with
// wrap, so the most recently served master has the lowest priority.
module rr_arbiter #(
    parameter int NUM_M = 2,
    parameter int IW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [IW-1:0]    i_last_grant,
    output logic [NUM_M-1:0] o_grant,
    output logic [IW-1:0]    o_grant_idx,
    output logic             o_valid
);

    // Walk the masters in rotated order and take the first requester.
    always_comb begin
        int idx;
        idx         = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = int'(i_last_grant) + k;
            if (idx >= NUM_M) begin
                idx = idx - NUM_M;
            end
            if (!o_valid && i_req[idx]) begin
                o_valid      = 1'b1;
                o_grant[idx] = 1'b1;
                o_grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_wb_arbiter.sv
// Shares one mem_wb port between NUM_M masters. A winner is latched in IDLE,
// the memory strobe is held through BUSY until ack or timeout, and a single
// one-cycle ack/err pulse is returned to that master in RESP.
module mem_wb_arbiter
    import mem_wb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int AW      = MEM_AW,
    parameter int DW      = MEM_DW,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_M-1:0]  i_m_strb,
    input  logic [NUM_M-1:0]  i_m_we,
    input  logic [NUM_M*AW-1:0] i_m_addr,
    input  logic [NUM_M*DW-1:0] i_m_wdata,
    output logic [DW-1:0]     o_m_rdata,
    output logic [NUM_M-1:0]  o_m_ack,
    output logic [NUM_M-1:0]  o_m_err,
    output logic              o_s_strb,
    output logic              o_s_we,
    output logic [AW-1:0]     o_s_addr,
    output logic [DW-1:0]     o_s_wdata,
    input  logic [DW-1:0]     i_s_rdata,
    input  logic              i_s_ack
);

    localparam int IW = $clog2(NUM_M);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic             w_done_ack;
    logic             w_done_err;

    logic [IW-1:0]    r_last_grant;
    logic [IW-1:0]    r_grant_idx;
    logic [NUM_M-1:0] r_grant_oh;
    logic [CW-1:0]    r_cnt;
    logic             r_s_we;
    logic [AW-1:0]    r_s_addr;
    logic [DW-1:0]    r_s_wdata;
    logic [DW-1:0]    r_m_rdata;
    logic [NUM_M-1:0] r_m_ack;
    logic [NUM_M-1:0] r_m_err;

    logic [NUM_M-1:0] w_grant;
    logic [IW-1:0]    w_grant_idx;
    logic             w_req_valid;
    logic             w_win_we;
    logic [AW-1:0]    w_win_addr;
    logic [DW-1:0]    w_win_wdata;

    rr_arbiter #(
        .NUM_M (NUM_M),
        .IW    (IW)
    ) u_rr (
        .i_req        (i_m_strb),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_valid      (w_req_valid)
    );

    assign w_win_we    = i_m_we[w_grant_idx];
    assign w_win_addr  = i_m_addr[w_grant_idx*AW +: AW];
    assign w_win_wdata = i_m_wdata[w_grant_idx*DW +: DW];

    // Strobe is decoded from state so an asynchronous reset drops it at once.
    assign o_s_strb  = (r_state == BUSY);
    assign o_s_we    = r_s_we;
    assign o_s_addr  = r_s_addr;
    assign o_s_wdata = r_s_wdata;
    assign o_m_rdata = r_m_rdata;
    assign o_m_ack   = r_m_ack;
    assign o_m_err   = r_m_err;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and completion decode; ack takes precedence over timeout.
    always_comb begin
        w_next_state = r_state;
        w_done_ack   = 1'b0;
        w_done_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_valid) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (i_s_ack) begin
                    w_done_ack   = 1'b1;
                    w_next_state = RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_done_err   = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latch the winner, run the saturating timeout counter, and produce the
    // one-cycle response pulses and read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= IW'(NUM_M - 1);
            r_grant_idx  <= '0;
            r_grant_oh   <= '0;
            r_cnt        <= '0;
            r_s_we       <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_m_rdata    <= '0;
            r_m_ack      <= '0;
            r_m_err      <= '0;
        end else begin
            r_m_ack <= '0;
            r_m_err <= '0;
            case (r_state)
                IDLE: begin
                    if (w_req_valid) begin
                        r_grant_idx <= w_grant_idx;
                        r_grant_oh  <= w_grant;
                        r_s_we      <= w_win_we;
                        r_s_addr    <= w_win_addr;
                        r_s_wdata   <= w_win_wdata;
                        r_cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_done_ack) begin
                        r_m_ack      <= r_grant_oh;
                        r_last_grant <= r_grant_idx;
                        if (!r_s_we) begin
                            r_m_rdata <= i_s_rdata;
                        end
                    end else if (w_done_err) begin
                        r_m_err      <= r_grant_oh;
                        r_last_grant <= r_grant_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_arbiter.sv
// Scoreboard bench for mem_wb_arbiter: a memory slave with selectable ack
// behaviour, a round-robin reference model that predicts each transaction
// when the memory strobe rises, and a monitor that checks every response.
module tb_mem_wb_arbiter;

    localparam int NM = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct {
        int             master;
        logic           we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
    } req_t;

    typedef struct {
        int             master;
        logic           err;
        logic [DW-1:0]  rdata;
        int             len;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM-1:0]     mStrb = '0;
    logic [NM-1:0]     mWe = '0;
    logic [NM*AW-1:0]  mAddr = '0;
    logic [NM*DW-1:0]  mWdata = '0;
    logic [DW-1:0]     oMRdata;
    logic [NM-1:0]     oMAck;
    logic [NM-1:0]     oMErr;
    logic              oSStrb;
    logic              oSWe;
    logic [AW-1:0]     oSAddr;
    logic [DW-1:0]     oSWdata;
    logic [DW-1:0]     sRdata = '0;
    logic              sAck = 1'b0;

    int checks = 0;
    int failures = 0;

    req_t pendQ[$];
    exp_t expQ[$];
    logic [NM-1:0] busy = '0;

    int slaveMode = 0;
    int slaveCnt = 0;
    int slaveAckAt = 0;
    logic [DW-1:0] slaveMem [256];
    logic [DW-1:0] modelMem [256];
    logic [DW-1:0] modelRdata = '0;
    int modelLast = NM - 1;
    logic prevStrb = 1'b0;
    int lowRun = 2;
    int runHi = 0;
    int doneLen = 0;

    logic [NM-1:0]    snapReq;
    logic [NM-1:0]    snapWe;
    logic [NM*AW-1:0] snapAddr;
    logic [NM*DW-1:0] snapWdata;

    always #5 clk = ~clk;

    mem_wb_arbiter #(
        .NUM_M   (NM),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_m_strb  (mStrb),
        .i_m_we    (mWe),
        .i_m_addr  (mAddr),
        .i_m_wdata (mWdata),
        .o_m_rdata (oMRdata),
        .o_m_ack   (oMAck),
        .o_m_err   (oMErr),
        .o_s_strb  (oSStrb),
        .o_s_we    (oSWe),
        .o_s_addr  (oSAddr),
        .o_s_wdata (oSWdata),
        .i_s_rdata (sRdata),
        .i_s_ack   (sAck)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_t r;
        r.master = m;
        r.we     = we;
        r.addr   = addr;
        r.wdata  = wdata;
        pendQ.push_back(r);
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (n < budget && !(pendQ.size() == 0 && busy == '0 && expQ.size() == 0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_timeout actual=%0d expected=<%0d", n, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    // Inputs as the arbiter saw them at each rising edge.
    always @(posedge clk) begin
        snapReq   <= mStrb;
        snapWe    <= mWe;
        snapAddr  <= mAddr;
        snapWdata <= mWdata;
    end

    // Memory slave plus reference model: predicts winner and outcome on strobe rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            slaveCnt   = 0;
            sAck       = 1'b0;
            prevStrb   = 1'b0;
            lowRun     = 2;
            modelLast  = NM - 1;
            modelRdata = '0;
        end else begin
            sAck   = 1'b0;
            sRdata = DW'($urandom);
            if (oSStrb) begin
                slaveCnt++;
                if (slaveCnt == 1) begin
                    case (slaveMode)
                        0:       slaveAckAt = int'($urandom_range(1, 4));
                        1:       slaveAckAt = 0;
                        2:       slaveAckAt = TO;
                        default: slaveAckAt = int'($urandom_range(1, 20));
                    endcase
                end
                if (slaveCnt == slaveAckAt) begin
                    sAck   = 1'b1;
                    sRdata = slaveMem[oSAddr];
                    if (oSWe) slaveMem[oSAddr] = oSWdata;
                end
            end else begin
                slaveCnt = 0;
            end

            if (oSStrb && !prevStrb) begin
                int w;
                exp_t e;
                checkOutput("strobe_gap_ge2", 32'(lowRun >= 2), 32'd1);
                w = -1;
                for (int k = 1; k <= NM; k++) begin
                    int c;
                    c = (modelLast + k) % NM;
                    if (w < 0 && snapReq[c]) w = c;
                end
                if (w < 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL strobe_without_request actual=%0b expected=0", oSStrb);
                end else begin
                    checkOutput("s_fields", {15'd0, oSWe, oSAddr, oSWdata},
                                {15'd0, snapWe[w], snapAddr[w*AW +: AW], snapWdata[w*DW +: DW]});
                    e.master = w;
                    e.err    = (slaveAckAt == 0 || slaveAckAt > TO);
                    e.len    = e.err ? TO : slaveAckAt;
                    if (!e.err) begin
                        if (snapWe[w]) modelMem[snapAddr[w*AW +: AW]] = snapWdata[w*DW +: DW];
                        else modelRdata = modelMem[snapAddr[w*AW +: AW]];
                    end
                    e.rdata   = modelRdata;
                    modelLast = w;
                    expQ.push_back(e);
                end
            end
            lowRun   = oSStrb ? 0 : lowRun + 1;
            prevStrb = oSStrb;
        end
    end

    // Monitor compares every response to the scoreboard, then the master driver reloads idle masters.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            busy    = '0;
            mStrb   = '0;
            runHi   = 0;
            doneLen = 0;
        end else begin
            if (oSStrb) begin
                runHi++;
            end else if (runHi != 0) begin
                doneLen = runHi;
                runHi   = 0;
            end
            if ((oMAck | oMErr) != '0) begin
                checkOutput("ack_err_exclusive", 32'(oMAck & oMErr), 32'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_response actual=ack%0b/err%0b expected=none", oMAck, oMErr);
                end else begin
                    exp_t e;
                    logic [NM-1:0] oh;
                    e  = expQ.pop_front();
                    oh = '0;
                    oh[e.master] = 1'b1;
                    checkOutput("m_ack", 32'(oMAck), e.err ? 32'd0 : 32'(oh));
                    checkOutput("m_err", 32'(oMErr), e.err ? 32'(oh) : 32'd0);
                    checkOutput("m_rdata", 32'(oMRdata), 32'(e.rdata));
                    checkOutput("strobe_len", 32'(doneLen), 32'(e.len));
                    busy[e.master] = 1'b0;
                end
            end
            for (int m = 0; m < NM; m++) begin
                if (!busy[m]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < pendQ.size(); i++) begin
                        if (idx < 0 && pendQ[i].master == m) idx = i;
                    end
                    if (idx >= 0) begin
                        mStrb[m]              = 1'b1;
                        mWe[m]                = pendQ[idx].we;
                        mAddr[m*AW +: AW]     = pendQ[idx].addr;
                        mWdata[m*DW +: DW]    = pendQ[idx].wdata;
                        busy[m]               = 1'b1;
                        pendQ.delete(idx);
                    end else begin
                        mStrb[m] = 1'b0;
                    end
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase and a mid-transaction reset.
    initial begin
        logic [AW-1:0] addrSet [4];
        int n;
        addrSet[0] = 8'h3C;
        addrSet[1] = 8'h40;
        addrSet[2] = 8'h41;
        addrSet[3] = 8'h10;
        for (int i = 0; i < 256; i++) begin
            slaveMem[i] = 8'h11;
            modelMem[i] = 8'h11;
        end

        rst_n = 1'b0;
        #1;
        checkOutput("reset_s_strb", 32'(oSStrb), 32'd0);
        checkOutput("reset_s_we", 32'(oSWe), 32'd0);
        checkOutput("reset_s_addr", 32'(oSAddr), 32'd0);
        checkOutput("reset_s_wdata", 32'(oSWdata), 32'd0);
        checkOutput("reset_m_rdata", 32'(oMRdata), 32'd0);
        checkOutput("reset_m_ack", 32'(oMAck), 32'd0);
        checkOutput("reset_m_err", 32'(oMErr), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        slaveMode = 0;
        applyStimulus(0, 1'b0, 8'h10, 8'h00);
        applyStimulus(1, 1'b0, 8'h20, 8'h00);
        waitDone(200);

        applyStimulus(0, 1'b1, 8'h3C, 8'hA5);
        waitDone(200);
        applyStimulus(1, 1'b0, 8'h3C, 8'h00);
        waitDone(200);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 8'h40 + 8'(i), 8'h60 + 8'(i));
            applyStimulus(1, 1'b0, 8'h40 + 8'(i), 8'h00);
        end
        waitDone(400);

        slaveMode = 1;
        applyStimulus(1, 1'b1, 8'h50, 8'h77);
        waitDone(200);
        slaveMode = 0;
        applyStimulus(0, 1'b0, 8'h50, 8'h00);
        waitDone(200);

        slaveMode = 2;
        applyStimulus(1, 1'b1, 8'h51, 8'h99);
        waitDone(200);
        slaveMode = 0;
        applyStimulus(0, 1'b0, 8'h51, 8'h00);
        waitDone(200);

        for (int r = 0; r < 12; r++) begin
            slaveMode = ($urandom_range(0, 3) == 0) ? 3 : 0;
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                applyStimulus(int'($urandom_range(0, NM - 1)), 1'($urandom), addrSet[$urandom_range(0, 3)], DW'($urandom));
            end
            waitDone(600);
        end

        slaveMode = 1;
        applyStimulus(1, 1'b0, 8'h55, 8'h00);
        n = 0;
        while (!oSStrb && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_s_strb", 32'(oSStrb), 32'd0);
        checkOutput("async_reset_m_ack", 32'(oMAck), 32'd0);
        checkOutput("async_reset_m_err", 32'(oMErr), 32'd0);
        pendQ.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        slaveMode = 0;
        applyStimulus(1, 1'b0, 8'h3C, 8'h00);
        applyStimulus(0, 1'b1, 8'hFF, 8'h5A);
        waitDone(200);
        applyStimulus(1, 1'b0, 8'hFF, 8'h00);
        waitDone(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
